obi_manager_be: RTL and testbench

// OBI manager (initiator) with byte-enable support: bridges a simple local cmd/rsp port to the OBI A/R channels
// of a byte-enabled subordinate. Generates be/lane-shifted wdata from size+offset, aligns and sign/zero-extends read

---
 rtl/obi_manager_be.sv | 234 +++++++++++++++++++++++
 tb/tb_obi_manager_be.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_manager_be.sv
// -----------------------------------------------------------------------------
// obi_manager_be
// OBI manager with byte-enable support. Bridges a local cmd/rsp port onto the
// OBI A (request) and R (response) channels of a byte-enabled subordinate.
// Byte enables and lane-shifted write data come from size + address offset.
// Read data is right-aligned and sign/zero-extended using per-transaction
// metadata that is queued at grant time. Up to MAX_OUTSTANDING granted
// transactions may be awaiting a response.
//
// Ports
//   clk_i, reset_ni                  clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o        local command handshake
//   cmd_addr_i, cmd_we_i             byte address, write enable
//   cmd_size_i                       0=byte 1=half 2=word 3=illegal
//   cmd_signed_i                     read: sign-extend (1) / zero-extend (0)
//   cmd_wdata_i                      LSB-aligned write data
//   rsp_valid_o / rsp_ready_i        local response handshake
//   rsp_rdata_o, rsp_err_o           aligned read data, error flag
//   obi_req_o / obi_gnt_i            OBI A-channel handshake
//   obi_addr_o, obi_we_o             OBI address, write enable
//   obi_be_o, obi_wdata_o            OBI byte enables, lane-positioned data
//   obi_rvalid_i / obi_rready_o      OBI R-channel handshake
//   obi_rdata_i, obi_err_i           OBI read data, subordinate error
// -----------------------------------------------------------------------------
module obi_manager_be #(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic                  cmd_we_i,
   input  logic [1:0]            cmd_size_i,
   input  logic                  cmd_signed_i,
   input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  obi_req_o,
   input  logic                  obi_gnt_i,
   output logic [ADDR_WIDTH-1:0] obi_addr_o,
   output logic                  obi_we_o,
   output logic [3:0]            obi_be_o,
   output logic [DATA_WIDTH-1:0] obi_wdata_o,
   input  logic                  obi_rvalid_i,
   output logic                  obi_rready_o,
   input  logic [DATA_WIDTH-1:0] obi_rdata_i,
   input  logic                  obi_err_i
);

   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

   typedef enum logic [1:0] {
      A_RESET,
      A_IDLE,
      A_REQ,
      A_ERR
   } state_t;

   // Everything the R path needs to post-process one response.
   typedef struct packed {
      logic [1:0] off;
      logic [1:0] size;
      logic       sgn;
      logic       we;
   } meta_t;

   state_t                r_state;
   logic                  r_req;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_we;
   logic [3:0]            r_be;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [1:0]            r_size;
   logic                  r_sgn;

   logic [CNT_W-1:0]      r_count;
   logic [PTR_W-1:0]      r_wptr;
   logic [PTR_W-1:0]      r_rptr;
   meta_t                 r_fifo [MAX_OUTSTANDING];

   logic                  w_misaligned;
   logic [3:0]            w_be;
   logic [4:0]            w_lane_shift;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic                  w_cmd_fire;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_fifo_empty;
   meta_t                 w_head;
   logic [DATA_WIDTH-1:0] w_rshift;
   logic [DATA_WIDTH-1:0] w_rdata;

   // ---------------------------------------------------------------- A path
   always_comb begin
      w_misaligned = 1'b0;
      case (cmd_size_i)
         2'd0:    w_misaligned = 1'b0;
         2'd1:    w_misaligned = cmd_addr_i[0];
         2'd2:    w_misaligned = |cmd_addr_i[1:0];
         default: w_misaligned = 1'b1;
      endcase
   end

   always_comb begin
      w_be = 4'b1111;
      case (cmd_size_i)
         2'd0:    w_be = 4'b0001 << cmd_addr_i[1:0];
         2'd1:    w_be = 4'b0011 << cmd_addr_i[1:0];
         default: w_be = 4'b1111;
      endcase
   end

   assign w_lane_shift = {cmd_addr_i[1:0], 3'b000};
   assign w_wdata      = cmd_we_i ? (cmd_wdata_i << w_lane_shift) : '0;

   // A local error is only accepted with nothing in flight so that its
   // response cannot overtake an earlier OBI response.
   assign cmd_ready_o = (r_state == A_IDLE) && (r_count < MAX_CNT) &&
                        (!w_misaligned || (r_count == '0));
   assign w_cmd_fire  = cmd_valid_i && cmd_ready_o;
   assign w_push      = r_req && obi_gnt_i;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_state <= A_RESET;
         r_req   <= 1'b0;
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_be    <= '0;
         r_wdata <= '0;
         r_size  <= '0;
         r_sgn   <= 1'b0;
      end else begin
         case (r_state)
            A_RESET: r_state <= A_IDLE;
            A_IDLE: begin
               if (w_cmd_fire) begin
                  if (w_misaligned) begin
                     r_state <= A_ERR;
                  end else begin
                     r_state <= A_REQ;
                     r_req   <= 1'b1;
                     r_addr  <= cmd_addr_i;
                     r_we    <= cmd_we_i;
                     r_be    <= w_be;
                     r_wdata <= w_wdata;
                     r_size  <= cmd_size_i;
                     r_sgn   <= cmd_signed_i;
                  end
               end
            end
            A_REQ: begin
               if (obi_gnt_i) begin
                  r_state <= A_IDLE;
                  r_req   <= 1'b0;
               end
            end
            A_ERR: begin
               if (rsp_ready_i) r_state <= A_IDLE;
            end
            default: r_state <= A_IDLE;
         endcase
      end
   end

   assign obi_req_o   = r_req;
   assign obi_addr_o  = r_addr;
   assign obi_we_o    = r_we;
   assign obi_be_o    = r_be;
   assign obi_wdata_o = r_wdata;

   // ------------------------------------------------------ outstanding FIFO
   assign w_fifo_empty = (r_count == '0);
   assign obi_rready_o = rsp_ready_i && (r_state != A_ERR) && (r_state != A_RESET);
   // A response with nothing outstanding is acknowledged but never pops.
   assign w_pop        = obi_rvalid_i && obi_rready_o && !w_fifo_empty;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_count <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
      end else begin
         if (w_push) r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + PTR_W'(1);
         if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
         else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) r_fifo[r_wptr] <= '{off: r_addr[1:0], size: r_size, sgn: r_sgn, we: r_we};
   end

   // ---------------------------------------------------------------- R path
   assign w_head   = r_fifo[r_rptr];
   assign w_rshift = obi_rdata_i >> {w_head.off, 3'b000};

   always_comb begin
      w_rdata = '0;
      if (!w_fifo_empty && !w_head.we) begin
         case (w_head.size)
            2'd0:    w_rdata = {{(DATA_WIDTH-8){w_head.sgn & w_rshift[7]}}, w_rshift[7:0]};
            2'd1:    w_rdata = {{(DATA_WIDTH-16){w_head.sgn & w_rshift[15]}}, w_rshift[15:0]};
            default: w_rdata = w_rshift;
         endcase
      end
   end

   assign rsp_valid_o = (r_state == A_ERR) || (obi_rvalid_i && (r_state != A_RESET));
   assign rsp_err_o   = (r_state == A_ERR) ? 1'b1 : obi_err_i;
   assign rsp_rdata_o = (r_state == A_ERR) ? '0 : w_rdata;

   // ------------------------------------------------------------ properties
   a_rvalid_needs_outstanding: assert property (
      @(posedge clk_i) disable iff (!reset_ni) obi_rvalid_i |-> !w_fifo_empty);

   a_count_bounded: assert property (
      @(posedge clk_i) disable iff (!reset_ni) r_count <= MAX_CNT);

   a_req_held_until_gnt: assert property (
      @(posedge clk_i) disable iff (!reset_ni)
      (r_req && !obi_gnt_i) |=> (r_req && $stable(r_addr) && $stable(r_we) &&
                                 $stable(r_be) && $stable(r_wdata)));

endmodule

// File: tb/tb_obi_manager_be.sv
// -----------------------------------------------------------------------------
// tb_obi_manager_be
// Directed bench for obi_manager_be. Stimulus pushes the expected A-channel
// beat and the expected local response into queues on command acceptance;
// independent monitors pop and compare whenever the DUT shows a grant or a
// response handshake. A small subordinate model returns queued read data.
// -----------------------------------------------------------------------------
module tb_obi_manager_be;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } a_t;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } r_t;

   logic        clk_i = 1'b0;
   logic        reset_ni;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic [31:0] cmd_addr_i;
   logic        cmd_we_i;
   logic [1:0]  cmd_size_i;
   logic        cmd_signed_i;
   logic [31:0] cmd_wdata_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        obi_req_o;
   logic        obi_gnt_i;
   logic [31:0] obi_addr_o;
   logic        obi_we_o;
   logic [3:0]  obi_be_o;
   logic [31:0] obi_wdata_o;
   logic        obi_rvalid_i;
   logic        obi_rready_o;
   logic [31:0] obi_rdata_i;
   logic        obi_err_i;

   logic gnt_en;
   logic r_en;

   a_t a_q[$];
   r_t sd_q[$];
   r_t rq[$];
   r_t exp_q[$];

   a_t   pend_a;
   r_t   pend_s;
   r_t   pend_r;
   logic pend_local;

   int n_checks = 0;
   int n_fail   = 0;
   int n_gnt    = 0;

   obi_manager_be #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .MAX_OUTSTANDING(2)
   ) dut (
      .clk_i        (clk_i),
      .reset_ni     (reset_ni),
      .cmd_valid_i  (cmd_valid_i),
      .cmd_ready_o  (cmd_ready_o),
      .cmd_addr_i   (cmd_addr_i),
      .cmd_we_i     (cmd_we_i),
      .cmd_size_i   (cmd_size_i),
      .cmd_signed_i (cmd_signed_i),
      .cmd_wdata_i  (cmd_wdata_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_rdata_o  (rsp_rdata_o),
      .rsp_err_o    (rsp_err_o),
      .obi_req_o    (obi_req_o),
      .obi_gnt_i    (obi_gnt_i),
      .obi_addr_o   (obi_addr_o),
      .obi_we_o     (obi_we_o),
      .obi_be_o     (obi_be_o),
      .obi_wdata_o  (obi_wdata_o),
      .obi_rvalid_i (obi_rvalid_i),
      .obi_rready_o (obi_rready_o),
      .obi_rdata_i  (obi_rdata_i),
      .obi_err_i    (obi_err_i)
   );

   always #5 clk_i = ~clk_i;

   assign obi_gnt_i = obi_req_o && gnt_en;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Subordinate: a grant moves the next prepared response into the R queue;
   // rvalid is offered from the cycle after the grant while r_en is high.
   initial begin : subordinate
      logic s_pop;
      logic s_push;
      r_t   tmp;
      obi_rvalid_i = 1'b0;
      obi_rdata_i  = '0;
      obi_err_i    = 1'b0;
      forever begin
         @(negedge clk_i);
         s_pop  = obi_rvalid_i && obi_rready_o;
         s_push = obi_req_o && obi_gnt_i;
         @(posedge clk_i);
         #2;
         if (!reset_ni) begin
            rq.delete();
         end else begin
            if (s_pop && rq.size() != 0) tmp = rq.pop_front();
            if (s_push && sd_q.size() != 0) rq.push_back(sd_q.pop_front());
         end
         obi_rvalid_i = r_en && (rq.size() != 0) && reset_ni;
         if (rq.size() != 0) begin
            obi_rdata_i = rq[0].data;
            obi_err_i   = rq[0].err;
         end else begin
            obi_rdata_i = '0;
            obi_err_i   = 1'b0;
         end
      end
   end

   always @(negedge clk_i) begin : a_monitor
      a_t a;
      if (reset_ni && obi_req_o && obi_gnt_i) begin
         n_gnt++;
         if (a_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL a_unexpected: got grant addr 0x%08h, expected no OBI beat (t=%0t)", obi_addr_o, $time);
         end else begin
            a = a_q.pop_front();
            check("a_addr",  obi_addr_o,  a.addr);
            check("a_we",    obi_we_o,    a.we);
            check("a_be",    obi_be_o,    a.be);
            check("a_wdata", obi_wdata_o, a.wdata);
         end
      end
   end

   always @(negedge clk_i) begin : r_monitor
      r_t r;
      if (reset_ni && rsp_valid_o && rsp_ready_i) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_unexpected: got rdata 0x%08h err %0b, expected no response (t=%0t)", rsp_rdata_o, rsp_err_o, $time);
         end else begin
            r = exp_q.pop_front();
            check("rsp_rdata", rsp_rdata_o, r.data);
            check("rsp_err",   rsp_err_o,   r.err);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic drive_cmd(input logic [31:0] addr, input logic we, input logic [1:0] size,
                            input logic sgn, input logic [31:0] wdata,
                            input logic [3:0] e_be, input logic [31:0] e_wdata,
                            input logic [31:0] s_data, input logic s_err,
                            input logic [31:0] e_rdata, input logic e_err, input logic e_local);
      cmd_valid_i  = 1'b1;
      cmd_addr_i   = addr;
      cmd_we_i     = we;
      cmd_size_i   = size;
      cmd_signed_i = sgn;
      cmd_wdata_i  = wdata;
      pend_a       = '{addr: addr, we: we, be: e_be, wdata: e_wdata};
      pend_s       = '{data: s_data, err: s_err};
      pend_r       = '{data: e_rdata, err: e_err};
      pend_local   = e_local;
   endtask

   // Returns at posedge+1 just after the accepting edge.
   task automatic wait_accept(input string nm);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk_i);
         if (cmd_ready_o) begin
            ok = 1'b1;
            if (!pend_local) begin
               a_q.push_back(pend_a);
               sd_q.push_back(pend_s);
            end
            exp_q.push_back(pend_r);
         end
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_accept: got no cmd_ready_o within 60 cycles, expected acceptance", nm);
      end
      @(posedge clk_i);
      #1;
      cmd_valid_i = 1'b0;
   endtask

   task automatic issue(input string nm, input logic [31:0] addr, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [31:0] wdata,
                        input logic [3:0] e_be, input logic [31:0] e_wdata,
                        input logic [31:0] s_data, input logic s_err,
                        input logic [31:0] e_rdata, input logic e_err, input logic e_local);
      drive_cmd(addr, we, size, sgn, wdata, e_be, e_wdata, s_data, s_err, e_rdata, e_err, e_local);
      wait_accept(nm);
   endtask

   task automatic wait_drain(input string nm);
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) cyc(1);
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_drain: got %0d responses pending after 100 cycles, expected 0", nm, exp_q.size());
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int g0;
      reset_ni     = 1'b0;
      cmd_valid_i  = 1'b0;
      cmd_addr_i   = '0;
      cmd_we_i     = 1'b0;
      cmd_size_i   = 2'd2;
      cmd_signed_i = 1'b0;
      cmd_wdata_i  = '0;
      rsp_ready_i  = 1'b1;
      gnt_en       = 1'b1;
      r_en         = 1'b1;

      // Reset values
      cyc(3);
      check("rst_req",     obi_req_o,    0);
      check("rst_we",      obi_we_o,     0);
      check("rst_be",      obi_be_o,     0);
      check("rst_addr",    obi_addr_o,   0);
      check("rst_wdata",   obi_wdata_o,  0);
      check("rst_cmd_rdy", cmd_ready_o,  0);
      check("rst_rsp_vld", rsp_valid_o,  0);
      check("rst_rready",  obi_rready_o, 0);
      reset_ni = 1'b1;
      #1;
      check("areset_cmd_rdy", cmd_ready_o,  0);
      check("areset_rready",  obi_rready_o, 0);
      cyc(1);
      check("idle_cmd_rdy", cmd_ready_o,  1);
      check("idle_rready",  obi_rready_o, 1);

      // Word write: write responses carry rdata 0 whatever the bus returns
      issue("t1_word_wr", 32'h10, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF,
            4'hF, 32'hDEADBEEF, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 1'b0);
      check("t1_req_latency", obi_req_o, 1);
      wait_drain("t1");

      // Reads and writes of every size and lane
      issue("t2_byte_rd_s", 32'h13, 1'b0, 2'd0, 1'b1, 32'h55,
            4'b1000, 32'h0, 32'h80AA_BBCC, 1'b0, 32'hFFFF_FF80, 1'b0, 1'b0);
      issue("t2_byte_rd_u", 32'h13, 1'b0, 2'd0, 1'b0, 32'h0,
            4'b1000, 32'h0, 32'h80AA_BBCC, 1'b0, 32'h0000_0080, 1'b0, 1'b0);
      issue("t2_half_rd_s", 32'h02, 1'b0, 2'd1, 1'b1, 32'h0,
            4'b1100, 32'h0, 32'h8001_7FFF, 1'b0, 32'hFFFF_8001, 1'b0, 1'b0);
      issue("t2_half_rd_u", 32'h00, 1'b0, 2'd1, 1'b0, 32'h0,
            4'b0011, 32'h0, 32'h1234_F00D, 1'b0, 32'h0000_F00D, 1'b0, 1'b0);
      issue("t2_byte_rd_pos", 32'h11, 1'b0, 2'd0, 1'b1, 32'h0,
            4'b0010, 32'h0, 32'h0000_7F00, 1'b0, 32'h0000_007F, 1'b0, 1'b0);
      issue("t2_byte_wr", 32'h12, 1'b1, 2'd0, 1'b0, 32'hAB,
            4'b0100, 32'h00AB_0000, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      issue("t2_word_rd_s", 32'h14, 1'b0, 2'd2, 1'b1, 32'h0,
            4'hF, 32'h0, 32'h8000_0001, 1'b0, 32'h8000_0001, 1'b0, 1'b0);
      wait_drain("t2");

      // Half write with grant withheld for three cycles
      gnt_en = 1'b0;
      issue("t3_half_wr", 32'h06, 1'b1, 2'd1, 1'b0, 32'h1234,
            4'b1100, 32'h1234_0000, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) gnt_en = 1'b1;
         @(negedge clk_i);
         check("t3_req_held", obi_req_o,   1);
         check("t3_addr",     obi_addr_o,  32'h06);
         check("t3_be",       obi_be_o,    4'b1100);
         check("t3_wdata",    obi_wdata_o, 32'h1234_0000);
         check("t3_we",       obi_we_o,    1);
         @(posedge clk_i);
         #1;
      end
      check("t3_req_drop", obi_req_o, 0);
      wait_drain("t3");

      // Outstanding limit: two granted reads stall the third
      g0   = n_gnt;
      r_en = 1'b0;
      issue("t4_rd1", 32'h20, 1'b0, 2'd2, 1'b0, 32'h0,
            4'hF, 32'h0, 32'h1111_1111, 1'b0, 32'h1111_1111, 1'b0, 1'b0);
      issue("t4_rd2", 32'h24, 1'b0, 2'd2, 1'b0, 32'h0,
            4'hF, 32'h0, 32'h2222_2222, 1'b0, 32'h2222_2222, 1'b0, 1'b0);
      drive_cmd(32'h28, 1'b0, 2'd2, 1'b0, 32'h0,
                4'hF, 32'h0, 32'h3333_3333, 1'b0, 32'h3333_3333, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         check("t4_stall_cmd_rdy", cmd_ready_o, 0);
         @(posedge clk_i);
         #1;
      end
      check("t4_two_granted", 32'(n_gnt - g0), 2);
      r_en = 1'b1;
      cyc(1);
      r_en = 1'b0;
      wait_accept("t4_rd3");
      r_en = 1'b1;
      wait_drain("t4");
      check("t4_three_granted", 32'(n_gnt - g0), 3);

      // Misaligned half read waits for the earlier response, then errors locally
      g0   = n_gnt;
      r_en = 1'b0;
      issue("t5_rd", 32'h50, 1'b0, 2'd2, 1'b0, 32'h0,
            4'hF, 32'h0, 32'h5A5A_5A5A, 1'b0, 32'h5A5A_5A5A, 1'b0, 1'b0);
      drive_cmd(32'h01, 1'b0, 2'd1, 1'b0, 32'h0,
                4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check("t5_err_waits", cmd_ready_o, 0);
         @(posedge clk_i);
         #1;
      end
      r_en = 1'b1;
      wait_accept("t5_misaligned");
      check("t5_no_req",  obi_req_o,   0);
      check("t5_rsp_vld", rsp_valid_o, 1);
      check("t5_rsp_err", rsp_err_o,   1);
      wait_drain("t5");
      issue("t5_size3", 32'h00, 1'b0, 2'd3, 1'b0, 32'h0,
            4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
      wait_drain("t5b");
      rsp_ready_i = 1'b0;
      issue("t5_word_off2", 32'h02, 1'b1, 2'd2, 1'b0, 32'hFFFF_FFFF,
            4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check("t5_err_hold_vld",   rsp_valid_o,  1);
         check("t5_err_hold_rready", obi_rready_o, 0);
         check("t5_err_hold_rdata", rsp_rdata_o,  0);
         check("t5_err_hold_req",   obi_req_o,    0);
         @(posedge clk_i);
         #1;
      end
      rsp_ready_i = 1'b1;
      wait_drain("t5c");
      check("t5_no_grants", 32'(n_gnt - g0), 1);

      // Subordinate error passes through
      issue("t6_wr_err", 32'h60, 1'b1, 2'd2, 1'b0, 32'hA5A5_A5A5,
            4'hF, 32'hA5A5_A5A5, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
      wait_drain("t6");

      // Reset with one read outstanding and a write request pending
      r_en = 1'b0;
      issue("t7_rd", 32'h74, 1'b0, 2'd2, 1'b0, 32'h0,
            4'hF, 32'h0, 32'h7777_7777, 1'b0, 32'h7777_7777, 1'b0, 1'b0);
      cyc(1);
      gnt_en = 1'b0;
      issue("t7_wr", 32'h70, 1'b1, 2'd2, 1'b0, 32'h0BAD_0BAD,
            4'hF, 32'h0BAD_0BAD, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("t7_req_pending", obi_req_o, 1);
      check("t7_count_one",   32'(dut.r_count), 1);
      reset_ni = 1'b0;
      #1;
      check("t7_req_cleared",   obi_req_o,   0);
      check("t7_count_cleared", 32'(dut.r_count), 0);
      check("t7_rsp_vld",       rsp_valid_o, 0);
      check("t7_cmd_rdy",       cmd_ready_o, 0);
      a_q.delete();
      sd_q.delete();
      exp_q.delete();
      r_en   = 1'b1;
      gnt_en = 1'b1;
      cyc(2);
      reset_ni = 1'b1;
      cyc(1);
      issue("t7_clean_rd", 32'h40, 1'b0, 2'd2, 1'b0, 32'h0,
            4'hF, 32'h0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0);
      wait_drain("t7");

      cyc(2);
      check("end_a_q_empty",  32'(a_q.size()),  0);
      check("end_sd_q_empty", 32'(sd_q.size()), 0);
      check("end_count_zero", 32'(dut.r_count), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
